// File: rtl/display_scan_if.sv
// Bundle between a time/alarm source and the 4-digit scan decoder:
// display content in, multiplexed pin drive and scan status out.
interface display_scan_if;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_in;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        scan_tick;

  modport master (
    output enable, digits_in, blank_mask, dp_in,
    input  anode, seg, dp, digit_idx, scan_tick
  );

  modport slave (
    input  enable, digits_in, blank_mask, dp_in,
    output anode, seg, dp, digit_idx, scan_tick
  );
endinterface

// File: rtl/display_scan_decoder.sv
// Time-multiplexed 4-digit 7-segment driver: a prescaled 2-bit scan index is
// one-hot decoded to digit enables while the selected BCD nibble drives the segments.
module display_scan_decoder #(
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  display_scan_if.slave bus
);

  localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  // XOR masks: logical value ^ mask = pin level, and the mask alone is "dark"
  localparam logic [3:0] AN_OFF  = {4{ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [CNT_W-1:0] r_pre_cnt;
  logic [1:0]       r_digit_idx;
  logic             r_scan_tick;
  logic [3:0]       r_anode;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_wrap;
  logic [3:0]       w_nibble;
  logic             w_blank;
  logic [3:0]       w_anode_log;
  logic [6:0]       w_seg_log;
  logic             w_dp_log;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = 7'h00;
    endcase
  endfunction

  assign w_wrap = (r_pre_cnt == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt   <= '0;
      r_digit_idx <= '0;
      r_scan_tick <= 1'b0;
    end else if (bus.enable) begin
      if (w_wrap) begin
        r_pre_cnt   <= '0;
        r_scan_tick <= 1'b1;
        r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
        r_pre_cnt   <= r_pre_cnt + CNT_W'(1);
        r_scan_tick <= 1'b0;
      end
    end else begin
      r_scan_tick <= 1'b0;
    end
  end

  // NOTE: every signal gets a value on every path through always_comb, so no
  // latch can be inferred.
  always_comb begin
    w_nibble    = bus.digits_in[{r_digit_idx, 2'b00} +: 4];
    w_blank     = bus.blank_mask[r_digit_idx];
    w_anode_log = (4'b0001 << r_digit_idx) & ~bus.blank_mask;
    w_seg_log   = w_blank ? 7'h00 : bcd_to_seg(w_nibble);
    w_dp_log    = bus.dp_in[r_digit_idx] & ~w_blank;
  end

  // Decode is registered from the pre-edge index, hence the one-cycle lag
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      r_anode <= AN_OFF;
      r_seg   <= SEG_OFF;
      r_dp    <= DP_OFF;
    end else begin
      r_anode <= w_anode_log ^ AN_OFF;
      r_seg   <= w_seg_log ^ SEG_OFF;
      r_dp    <= w_dp_log ^ DP_OFF;
    end
  end

  assign bus.anode     = r_anode;
  assign bus.seg       = r_seg;
  assign bus.dp        = r_dp;
  assign bus.digit_idx = r_digit_idx;
  assign bus.scan_tick = r_scan_tick;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Bench for display_scan_decoder: an active-low SCAN_DIV=4 build and an
// active-high SCAN_DIV=1 build share stimulus and are checked against a slot-count model.
module tb_display_scan_decoder;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_rst    = 1'b1;
  logic        t_en     = 1'b1;
  logic [15:0] t_digits = 16'h0000;
  logic [3:0]  t_blank  = 4'h0;
  logic [3:0]  t_dp     = 4'h0;

  display_scan_if bus_a ();
  display_scan_if bus_b ();

  assign bus_a.enable     = t_en;
  assign bus_a.digits_in  = t_digits;
  assign bus_a.blank_mask = t_blank;
  assign bus_a.dp_in      = t_dp;
  assign bus_b.enable     = t_en;
  assign bus_b.digits_in  = t_digits;
  assign bus_b.blank_mask = t_blank;
  assign bus_b.dp_in      = t_dp;

  display_scan_decoder #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(t_rst), .bus(bus_a));
  display_scan_decoder #(.SCAN_DIV(1), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset(t_rst), .bus(bus_b));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: the scan position is just the number of enabled cycles since reset
  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  int   m_n   [2] = '{0, 0};
  int   m_div [2] = '{4, 1};
  bit   m_al  [2] = '{1'b1, 1'b0};
  exp_t exp_o [2];

  task automatic model_step(input int k);
    int         old_idx;
    int         nib;
    bit         blanked;
    logic [3:0] an_l;
    logic [3:0] dark_an;
    logic [6:0] dark_seg;
    dark_an  = m_al[k] ? 4'hF : 4'h0;
    dark_seg = m_al[k] ? 7'h7F : 7'h00;
    old_idx  = (m_n[k] / m_div[k]) % 4;
    if (t_rst) begin
      m_n[k]        = 0;
      exp_o[k].an   = dark_an;
      exp_o[k].seg  = dark_seg;
      exp_o[k].dp   = m_al[k];
      exp_o[k].idx  = 2'd0;
      exp_o[k].tick = 1'b0;
    end else if (!t_en) begin
      exp_o[k].an   = dark_an;
      exp_o[k].seg  = dark_seg;
      exp_o[k].dp   = m_al[k];
      exp_o[k].idx  = 2'(old_idx);
      exp_o[k].tick = 1'b0;
    end else begin
      blanked = t_blank[old_idx];
      for (int i = 0; i < 4; i++) an_l[i] = (i == old_idx) && !t_blank[i];
      nib = (int'(t_digits) >> (4 * old_idx)) & 15;
      exp_o[k].an  = an_l ^ dark_an;
      exp_o[k].seg = (blanked ? 7'h00 : SEG_TAB[nib]) ^ dark_seg;
      exp_o[k].dp  = (t_dp[old_idx] && !blanked) ^ m_al[k];
      m_n[k]++;
      exp_o[k].tick = (m_n[k] % m_div[k]) == 0;
      exp_o[k].idx  = 2'((m_n[k] / m_div[k]) % 4);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("a.anode", 32'(bus_a.anode),     32'(exp_o[0].an));
    check("a.seg",   32'(bus_a.seg),       32'(exp_o[0].seg));
    check("a.dp",    32'(bus_a.dp),        32'(exp_o[0].dp));
    check("a.idx",   32'(bus_a.digit_idx), 32'(exp_o[0].idx));
    check("a.tick",  32'(bus_a.scan_tick), 32'(exp_o[0].tick));
    check("b.anode", 32'(bus_b.anode),     32'(exp_o[1].an));
    check("b.seg",   32'(bus_b.seg),       32'(exp_o[1].seg));
    check("b.dp",    32'(bus_b.dp),        32'(exp_o[1].dp));
    check("b.idx",   32'(bus_b.digit_idx), 32'(exp_o[1].idx));
    check("b.tick",  32'(bus_b.scan_tick), 32'(exp_o[1].tick));
  endtask

  // Literal vectors for the SCAN_DIV=4, active-low build
  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  dpi;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpo;
    logic [1:0]  idx;
    logic        tick;
  } vec_t;

  vec_t vec[$];

  task automatic add(input int n, input logic rst, input logic [3:0] an,
                     input logic [6:0] seg, input logic [1:0] idx, input logic tick);
    vec_t v;
    v = '{rst: rst, en: 1'b1, digits: 16'h1234, blank: 4'h0, dpi: 4'h0,
          an: an, seg: seg, dpo: 1'b1, idx: idx, tick: tick};
    for (int i = 0; i < n; i++) vec.push_back(v);
  endtask

  initial begin
    add(3, 1'b1, 4'hF, 7'h7F, 2'd0, 1'b0);
    add(3, 1'b0, 4'hE, 7'h19, 2'd0, 1'b0);
    add(1, 1'b0, 4'hE, 7'h19, 2'd1, 1'b1);
    add(3, 1'b0, 4'hD, 7'h30, 2'd1, 1'b0);
    add(1, 1'b0, 4'hD, 7'h30, 2'd2, 1'b1);
    add(3, 1'b0, 4'hB, 7'h24, 2'd2, 1'b0);
    add(1, 1'b0, 4'hB, 7'h24, 2'd3, 1'b1);
    add(3, 1'b0, 4'h7, 7'h79, 2'd3, 1'b0);
    add(1, 1'b0, 4'h7, 7'h79, 2'd0, 1'b1);
    add(1, 1'b0, 4'hE, 7'h19, 2'd0, 1'b0);

    // Reset, then free run over 1234
    foreach (vec[i]) begin
      t_rst = vec[i].rst; t_en = vec[i].en; t_digits = vec[i].digits;
      t_blank = vec[i].blank; t_dp = vec[i].dpi;
      cycle();
      check("vec.anode", 32'(bus_a.anode),     32'(vec[i].an));
      check("vec.seg",   32'(bus_a.seg),       32'(vec[i].seg));
      check("vec.dp",    32'(bus_a.dp),        32'(vec[i].dpo));
      check("vec.idx",   32'(bus_a.digit_idx), 32'(vec[i].idx));
      check("vec.tick",  32'(bus_a.scan_tick), 32'(vec[i].tick));
    end

    // Nibble sweep on digit0: reset, then one enabled cycle decodes digit0
    for (int v = 0; v < 16; v++) begin
      t_rst = 1'b1; t_en = 1'b1; t_blank = 4'h0; t_dp = 4'h0;
      cycle();
      t_rst = 1'b0; t_digits = 16'(v);
      cycle();
      check("sweep.a.seg",   32'(bus_a.seg),   32'(SEG_TAB[v] ^ 7'h7F));
      check("sweep.a.anode", 32'(bus_a.anode), 32'h0E);
      check("sweep.b.seg",   32'(bus_b.seg),   32'(SEG_TAB[v]));
      check("sweep.b.anode", 32'(bus_b.anode), 32'h01);
    end

    // Blanking digit2, decimal points on digits 0 and 2
    t_rst = 1'b1; cycle();
    t_rst = 1'b0; t_digits = 16'h1234; t_blank = 4'b0100; t_dp = 4'b0101;
    for (int e = 1; e <= 16; e++) begin
      cycle();
      if (e == 1) begin
        check("blank.d0.anode", 32'(bus_a.anode), 32'hE);
        check("blank.d0.dp",    32'(bus_a.dp),    32'h0);
      end
      if (e == 9) begin
        check("blank.d2.anode", 32'(bus_a.anode), 32'hF);
        check("blank.d2.seg",   32'(bus_a.seg),   32'h7F);
        check("blank.d2.dp",    32'(bus_a.dp),    32'h1);
      end
      if (e == 13) begin
        check("blank.d3.anode", 32'(bus_a.anode), 32'h7);
        check("blank.d3.dp",    32'(bus_a.dp),    32'h1);
      end
    end

    // Disable at pre_cnt=2, digit_idx=1 for five cycles, then resume
    t_blank = 4'h0; t_dp = 4'h0;
    t_rst = 1'b1; cycle();
    t_rst = 1'b0;
    repeat (6) cycle();
    t_en = 1'b0;
    repeat (5) begin
      cycle();
      check("dis.anode", 32'(bus_a.anode),     32'hF);
      check("dis.seg",   32'(bus_a.seg),       32'h7F);
      check("dis.dp",    32'(bus_a.dp),        32'h1);
      check("dis.tick",  32'(bus_a.scan_tick), 32'h0);
      check("dis.idx",   32'(bus_a.digit_idx), 32'h1);
    end
    t_en = 1'b1;
    cycle();
    check("resume1.anode", 32'(bus_a.anode),     32'hD);
    check("resume1.tick",  32'(bus_a.scan_tick), 32'h0);
    check("resume1.idx",   32'(bus_a.digit_idx), 32'h1);
    cycle();
    check("resume2.tick",  32'(bus_a.scan_tick), 32'h1);
    check("resume2.idx",   32'(bus_a.digit_idx), 32'h2);

    // Mid-scan reset of the SCAN_DIV=1 active-high build at digit_idx=3
    t_rst = 1'b1; cycle();
    t_rst = 1'b0;
    repeat (3) cycle();
    check("rst6.pre.idx", 32'(bus_b.digit_idx), 32'h3);
    t_rst = 1'b1; cycle();
    check("rst6.anode", 32'(bus_b.anode),     32'h0);
    check("rst6.seg",   32'(bus_b.seg),       32'h0);
    check("rst6.dp",    32'(bus_b.dp),        32'h0);
    check("rst6.idx",   32'(bus_b.digit_idx), 32'h0);
    check("rst6.tick",  32'(bus_b.scan_tick), 32'h0);
    t_rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      check("div1.idx",  32'(bus_b.digit_idx), 32'(i % 4));
      check("div1.tick", 32'(bus_b.scan_tick), 32'h1);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      t_rst    = ($urandom_range(0, 49) == 0);
      t_en     = ($urandom_range(0, 9) < 8);
      t_digits = 16'($urandom);
      t_blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      t_dp     = 4'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
